// File: rtl/frv_masked_b2a.sv
// Boolean-to-arithmetic mask conversion (Goubin), fully registered, one result per 4 cycles.
// Optional output refresh with fresh randomness z1 when FRV_MASKED_B2A_REFRESH_EN is defined.
module frv_masked_b2a #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic                 flush,
  input  logic                 valid,
  input  logic [BIT_WIDTH-1:0] rs1_s0,
  input  logic [BIT_WIDTH-1:0] rs1_s1,
  input  logic [BIT_WIDTH-1:0] z0,
  input  logic [BIT_WIDTH-1:0] z1,
  output logic [BIT_WIDTH-1:0] rd_s0,
  output logic [BIT_WIDTH-1:0] rd_s1,
  output logic                 ready,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_S1   = 2'd1;
  localparam logic [1:0] ST_S2   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [BIT_WIDTH-1:0] s0_q, s0_d;
  logic [BIT_WIDTH-1:0] s1_q, s1_d;
  logic [BIT_WIDTH-1:0] g_q, g_d;
  logic [BIT_WIDTH-1:0] t1_q, t1_d;
  logic [BIT_WIDTH-1:0] rd_s0_q, rd_s0_d;
  logic [BIT_WIDTH-1:0] rd_s1_q, rd_s1_d;

  // g2 mixes gamma into s1 first, so s0 and s1 only ever meet under the gamma mask.
  logic [BIT_WIDTH-1:0] g2;
  logic [BIT_WIDTH-1:0] a_share;

  assign g2      = g_q ^ s1_q;
  assign a_share = t1_q ^ s0_q ^ ((s0_q ^ g2) - g2);

  // Handshake: valid is held by the requester until ready; ready is a one-cycle
  // pulse decoded from the state register alone, and rd_s0/rd_s1 are valid with it.
  always_comb begin
    state_d = state_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    g_d     = g_q;
    t1_d    = t1_q;
    rd_s0_d = rd_s0_q;
    rd_s1_d = rd_s1_q;
    if (flush) begin
      state_d = ST_IDLE;
      s0_d    = '0;
      s1_d    = '0;
      g_d     = '0;
      t1_d    = '0;
      rd_s0_d = '0;
      rd_s1_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid) begin
            s0_d    = rs1_s0;
            s1_d    = rs1_s1;
            g_d     = z0;
            state_d = ST_S1;
          end
        end
        ST_S1: begin
          t1_d    = (s0_q ^ g_q) - g_q;
          state_d = ST_S2;
        end
        ST_S2: begin
`ifdef FRV_MASKED_B2A_REFRESH_EN
          rd_s0_d = a_share + z1;
          rd_s1_d = s1_q - z1;
`else
          rd_s0_d = a_share;
          rd_s1_d = s1_q;
`endif
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

`ifndef FRV_MASKED_B2A_REFRESH_EN
  logic unused_z1;
  assign unused_z1 = ^z1;
`endif

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
      s0_q    <= '0;
      s1_q    <= '0;
      g_q     <= '0;
      t1_q    <= '0;
      rd_s0_q <= '0;
      rd_s1_q <= '0;
    end else begin
      state_q <= state_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      g_q     <= g_d;
      t1_q    <= t1_d;
      rd_s0_q <= rd_s0_d;
      rd_s1_q <= rd_s1_d;
    end
  end

  assign rd_s0     = rd_s0_q;
  assign rd_s1     = rd_s1_q;
  assign ready     = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_frv_masked_b2a.sv
// Bench for frv_masked_b2a: directed vectors, flush/reset cases and 1000 back-to-back random ops
// checked every cycle against a latency/value model built from the conversion's arithmetic meaning.
module tb_frv_masked_b2a;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         valid = 1'b0;
  logic [W-1:0] s0 = '0, s1 = '0, z0 = '0, z1 = '0;
  logic [W-1:0] rd_s0, rd_s1;
  logic         ready;
  logic [1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  frv_masked_b2a #(.BIT_WIDTH(W)) dut (
    .g_clk(clk), .g_resetn(rst_n), .flush(flush), .valid(valid),
    .rs1_s0(s0), .rs1_s1(s1), .z0(z0), .z1(z1),
    .rd_s0(rd_s0), .rd_s1(rd_s1), .ready(ready), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Counts edges since acceptance; the result x - s1 (optionally refreshed by z1)
  // lands on the third edge and ready is seen for the cycle after it.
  int           m_age = 0;
  logic [W-1:0] m_x = '0, m_s1 = '0, m_rd0 = '0, m_rd1 = '0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age = 0; m_rd0 = '0; m_rd1 = '0;
      exp_q.delete();
    end else if (flush) begin
      m_age = 0; m_rd0 = '0; m_rd1 = '0;
      exp_q.delete();
    end else if (m_age == 0) begin
      if (valid) begin
        m_x  = s0 ^ s1;
        m_s1 = s1;
        exp_q.push_back(s0 ^ s1);
        m_age = 1;
      end
    end else if (m_age == 2) begin
      m_rd0 = m_x - m_s1;
      m_rd1 = m_s1;
`ifdef FRV_MASKED_B2A_REFRESH_EN
      m_rd0 = m_rd0 + z1;
      m_rd1 = m_rd1 - z1;
`endif
      m_age = 3;
    end else begin
      m_age = (m_age + 1) % 4;
    end
  end

  // ---------------- scoreboard / compare ----------------
  int cyc = 0;
  int last_ready = -1;
  bit chk_period = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] x;
    cyc++;
    if (rst_n) begin
      check("ready", {31'b0, ready}, {31'b0, (m_age == 3)});
      check("rd_s0", rd_s0, m_rd0);
      check("rd_s1", rd_s1, m_rd1);
      if (ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          x = exp_q.pop_front();
          check("share_sum", rd_s0 + rd_s1, x);
        end
        if (chk_period && last_ready >= 0) check("ready_period", cyc - last_ready, 32'd4);
        last_ready = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one request, scrambles the share/gamma inputs after acceptance,
  // and returns at the negedge where ready is high (bounded wait).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] g, input logic [W-1:0] r);
    bit seen;
    @(negedge clk);
    valid = 1'b1; s0 = a; s1 = b; z0 = g; z1 = r;
    @(negedge clk);
    valid = 1'b0; s0 = $urandom; s1 = $urandom; z0 = $urandom;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (ready) seen = 1'b1;
      else @(negedge clk);
    end
    check("ready_timeout", {31'b0, seen}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ops;
    int budget;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'b0, ready}, 32'd0);
    check("reset_rd_s0", rd_s0, 32'd0);
    check("reset_rd_s1", rd_s1, 32'd0);
    rst_n = 1'b1;

    // Vector 1: x = 6
    do_op(32'h00000005, 32'h00000003, 32'h12345678, 32'h00000000);
`ifdef FRV_MASKED_B2A_REFRESH_EN
    check("v1_sum", rd_s0 + rd_s1, 32'h00000006);
`else
    check("v1_rd_s0", rd_s0, 32'h00000003);
    check("v1_rd_s1", rd_s1, 32'h00000003);
`endif
    // Vector 2: borrow wrap
    do_op(32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h00000000);
    check("v2_rd_s0", rd_s0, 32'hFFFFFFFF);
    check("v2_rd_s1", rd_s1, 32'hFFFFFFFF);
    check("v2_sum", rd_s0 + rd_s1, 32'hFFFFFFFE);
    // Vector 3
    do_op(32'hA5A5A5A5, 32'h0F0F0F0F, 32'h3C3C3C3C, 32'h00000010);
`ifdef FRV_MASKED_B2A_REFRESH_EN
    check("v3_rd_s1", rd_s1, 32'h0F0F0EFF);
`else
    check("v3_rd_s0", rd_s0, 32'h9B9B9B9B);
    check("v3_rd_s1", rd_s1, 32'h0F0F0F0F);
`endif
    check("v3_sum", rd_s0 + rd_s1, 32'hAAAAAAAA);

    // Flush while in S1
    @(negedge clk);
    valid = 1'b1; s0 = 32'h11112222; s1 = 32'h33334444; z0 = $urandom;
    @(negedge clk);
    valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", {31'b0, ready}, 32'd0);
    check("flush_rd_s0", rd_s0, 32'd0);
    check("flush_rd_s1", rd_s1, 32'd0);
    repeat (4) @(negedge clk);
    check("flush_no_ready", {31'b0, ready}, 32'd0);
    do_op(32'h000000F0, 32'h0000000F, $urandom, 32'h00000000);
    check("post_flush_sum", rd_s0 + rd_s1, 32'h000000FF);

    // Flush in the DONE cycle: ready still high now, outputs clear on the edge
    do_op($urandom, $urandom, $urandom, $urandom);
    check("done_flush_ready", {31'b0, ready}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("done_flush_rd_s0", rd_s0, 32'd0);
    check("done_flush_rd_s1", rd_s1, 32'd0);

    // Reset pulse in S2
    do_op(32'h0000FFFF, 32'h12340000, $urandom, $urandom);
    @(negedge clk);
    valid = 1'b1; s0 = $urandom; s1 = $urandom; z0 = $urandom;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_rd_s0", rd_s0, 32'd0);
    check("rst_rd_s1", rd_s1, 32'd0);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("rst_no_ready", {31'b0, ready}, 32'd0);
    end

    // Back-to-back random: valid held high, fresh inputs every cycle
    last_ready = -1;
    chk_period = 1'b1;
    ops = 0;
    budget = 0;
    while (ops < 1000 && budget < 4100) begin
      @(negedge clk);
      if (ready) ops++;
      valid = 1'b1;
      s0 = $urandom; s1 = $urandom; z0 = $urandom; z1 = $urandom;
      budget++;
    end
    check("b2b_ops", ops, 32'd1000);
    valid = 1'b0;
    chk_period = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
